// File: rtl/lynx_noc_pkg.sv
// lynx_noc_pkg
//   Shared helpers for the NoC adapter blocks.
//   rr_pick   : rotate-priority search over a request vector, returning the
//               first asserted index at or after a start pointer (wrapping
//               at n) plus a found flag.
//   rr_pick_t : result record of rr_pick.
//   Request vectors up to RR_MAX_REQ entries are supported; callers
//   zero-extend narrower vectors and pass their real size in n.
package lynx_noc_pkg;

  localparam int RR_MAX_REQ = 32;
  // One bit wider than an index so ptr+offset never overflows before the wrap.
  localparam int RR_IDX_W   = 6;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // ptr < n and offset < n, so a single conditional subtract performs the wrap,
  // which keeps non-power-of-two sizes exact.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                       input logic [RR_IDX_W-1:0]   ptr,
                                       input logic [RR_IDX_W-1:0]   n);
    rr_pick_t            res;
    logic [RR_IDX_W-1:0] off;
    logic [RR_IDX_W-1:0] idx;
    res = '0;
    for (int k = 0; k < RR_MAX_REQ; k++) begin
      off = RR_IDX_W'(k);
      idx = ptr + off;
      if (idx >= n) idx = idx - n;
      if (!res.found && (off < n) && req[idx[RR_IDX_W-2:0]]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// rr_arbiter_core
//   Round-robin arbiter core: holds the priority pointer, searches the request
//   vector starting at the pointer, and advances the pointer past the winner
//   whenever the owner signals an accepted grant.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointer returns to 0)
//   i_req     : request vector, NUM_REQ bits
//   i_accept  : strobe, the current grant was consumed this cycle
//   o_found   : some request is asserted
//   o_grant   : winning index (valid when o_found)
module rr_arbiter_core
  import lynx_noc_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_accept,
  output logic                       o_found,
  output logic [$clog2(NUM_REQ)-1:0] o_grant
);

  localparam int REQ_WIDTH = $clog2(NUM_REQ);

  logic [REQ_WIDTH-1:0]  r_ptr;
  logic [RR_MAX_REQ-1:0] w_reqExt;
  rr_pick_t              w_pick;
  logic                  w_unusedIdx;

  assign w_reqExt    = RR_MAX_REQ'(i_req);
  assign w_pick      = rr_pick(w_reqExt, RR_IDX_W'(r_ptr), RR_IDX_W'(NUM_REQ));
  assign o_found     = w_pick.found;
  assign o_grant     = w_pick.idx[REQ_WIDTH-1:0];
  // Upper index bits are always zero for a legal pointer.
  assign w_unusedIdx = ^w_pick.idx[RR_IDX_W-1:REQ_WIDTH];

  // Pointer moves only on an accepted grant; the wrap is explicit so values
  // >= NUM_REQ are never produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      r_ptr <= (o_grant == REQ_WIDTH'(NUM_REQ - 1)) ? '0 : o_grant + REQ_WIDTH'(1);
    end
  end

endmodule

// File: rtl/packetizer_arb_da.sv
// packetizer_arb_da
//   Shares one packetizer input between NUM_REQ requesters. A round-robin
//   arbiter picks one valid requester per cycle; its fields are registered
//   into a single-entry output stage that feeds the packetizer. A word can
//   leave and a new one load in the same cycle (1 word/cycle).
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   data_in/dst_in/vc_in/
//   ret_dst_in/ret_vc_in             : packed per-requester fields (slice i)
//   valid_in / ready_out             : per-requester handshake
//   pk_*_out, pk_valid_out           : output stage toward the packetizer
//   pk_ready_in                      : packetizer accept
//   grant_idx_out                    : requester that owns the held word
module packetizer_arb_da
  import lynx_noc_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_IN         = 12
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ*WIDTH_IN-1:0]           data_in,
  input  logic [NUM_REQ-1:0]                    valid_in,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]      dst_in,
  input  logic [NUM_REQ*VC_ADDRESS_WIDTH-1:0]   vc_in,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]      ret_dst_in,
  input  logic [NUM_REQ*VC_ADDRESS_WIDTH-1:0]   ret_vc_in,
  output logic [NUM_REQ-1:0]                    ready_out,
  output logic [WIDTH_IN-1:0]                   pk_data_out,
  output logic [ADDRESS_WIDTH-1:0]              pk_dst_out,
  output logic [VC_ADDRESS_WIDTH-1:0]           pk_vc_out,
  output logic [ADDRESS_WIDTH-1:0]              pk_ret_dst_out,
  output logic [VC_ADDRESS_WIDTH-1:0]           pk_ret_vc_out,
  output logic                                  pk_valid_out,
  input  logic                                  pk_ready_in,
  output logic [$clog2(NUM_REQ)-1:0]            grant_idx_out
);

  localparam int REQ_WIDTH = $clog2(NUM_REQ);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0]    ret_dst;
    logic [VC_ADDRESS_WIDTH-1:0] ret_vc;
    logic [ADDRESS_WIDTH-1:0]    dst;
    logic [VC_ADDRESS_WIDTH-1:0] vc;
    logic [WIDTH_IN-1:0]         data;
  } req_fields_t;

  logic                 w_found;
  logic [REQ_WIDTH-1:0] w_grant;
  logic                 w_canLoad;
  logic                 w_accept;
  req_fields_t          w_sel;
  req_fields_t          r_out;
  logic                 r_valid;
  logic [REQ_WIDTH-1:0] r_grantIdx;

  rr_arbiter_core #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (valid_in),
    .i_accept (w_accept),
    .o_found  (w_found),
    .o_grant  (w_grant)
  );

  // The stage can take a word when empty or when its word leaves this cycle.
  assign w_canLoad = !r_valid || pk_ready_in;
  assign w_accept  = w_found && w_canLoad && !rst;

  always_comb begin
    ready_out = '0;
    if (w_accept) ready_out[w_grant] = 1'b1;
  end

  // Field mux: pick the granted requester's slices.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == REQ_WIDTH'(i)) begin
        w_sel.data    = data_in[i*WIDTH_IN +: WIDTH_IN];
        w_sel.dst     = dst_in[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        w_sel.vc      = vc_in[i*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH];
        w_sel.ret_dst = ret_dst_in[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        w_sel.ret_vc  = ret_vc_in[i*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH];
      end
    end
  end

  // Output stage: load on accept, drain when the packetizer takes the word
  // and nothing replaces it; fields keep their last value after a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_out      <= '0;
      r_grantIdx <= '0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_out      <= w_sel;
      r_grantIdx <= w_grant;
    end else if (w_canLoad) begin
      r_valid    <= 1'b0;
    end
  end

  assign pk_valid_out   = r_valid;
  assign pk_data_out    = r_out.data;
  assign pk_dst_out     = r_out.dst;
  assign pk_vc_out      = r_out.vc;
  assign pk_ret_dst_out = r_out.ret_dst;
  assign pk_ret_vc_out  = r_out.ret_vc;
  assign grant_idx_out  = r_grantIdx;

  a_readyOneHot: assert property (@(posedge clk) $onehot0(ready_out));

  // Requesters must hold valid and fields steady until their transfer.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_contract
    a_reqHold: assert property (@(posedge clk) disable iff (rst)
      (valid_in[g] && !ready_out[g]) |=>
        (valid_in[g]
         && $stable(data_in[g*WIDTH_IN +: WIDTH_IN])
         && $stable(dst_in[g*ADDRESS_WIDTH +: ADDRESS_WIDTH])
         && $stable(vc_in[g*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH])
         && $stable(ret_dst_in[g*ADDRESS_WIDTH +: ADDRESS_WIDTH])
         && $stable(ret_vc_in[g*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH])));
  end

endmodule

// File: doc/packetizer_arb_da.md
Name: packetizer_arb_da

Overview:
- Round-robin arbiter that shares one packetizer_da instance between NUM_REQ requesters, e.g. several module ports behind one NoC router port.
- Each requester presents a data word, destination, VC, return destination and return VC with a valid/ready handshake.
- The arbiter grants one requester per cycle and registers the winner into a single-entry output stage.
- That output stage drives the packetizer's input port.

Parameters:
- NUM_REQ, 4: number of requesters, ≥2.
- ADDRESS_WIDTH, 4: router address width.
- VC_ADDRESS_WIDTH, 1: VC id width.
- WIDTH_IN, 12: payload width per requester.
- REQ_WIDTH, $clog2(NUM_REQ): grant index width (localparam).

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- data_in, input, NUM_REQ*WIDTH_IN: requester payloads; requester i occupies slice [i*WIDTH_IN +: WIDTH_IN].
- valid_in, input, NUM_REQ: per-requester valid.
- dst_in, input, NUM_REQ*ADDRESS_WIDTH: per-requester destination.
- vc_in, input, NUM_REQ*VC_ADDRESS_WIDTH: per-requester VC.
- ret_dst_in, input, NUM_REQ*ADDRESS_WIDTH: per-requester return destination.
- ret_vc_in, input, NUM_REQ*VC_ADDRESS_WIDTH: per-requester return VC.
- ready_out, output, NUM_REQ: per-requester accept.
- pk_data_out, output, WIDTH_IN: payload to the packetizer.
- pk_dst_out, output, ADDRESS_WIDTH: destination to the packetizer.
- pk_vc_out, output, VC_ADDRESS_WIDTH: VC to the packetizer.
- pk_ret_dst_out, output, ADDRESS_WIDTH: return destination to the packetizer.
- pk_ret_vc_out, output, VC_ADDRESS_WIDTH: return VC to the packetizer.
- pk_valid_out, output, 1: output stage holds a word.
- pk_ready_in, input, 1: packetizer ready_out.
- grant_idx_out, output, REQ_WIDTH: index of the requester whose word is in the output stage (debug/statistics).

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - pk_valid_out=0; all pk_* data fields=0; grant_idx_out=0.
  - RR pointer=0.
  - ready_out=0 combinationally while rst is high.
  - Reset mid-transfer discards the held word with no other side effect.
- Load enable: can_load = !pk_valid_out | pk_ready_in.
  - A word may leave and a new word may load in the same cycle, giving full throughput of 1 word/cycle.
- Arbitration (combinational):
  - Search valid_in starting at index ptr, wrapping from NUM_REQ-1 to 0.
  - The first asserted index wins (grant).
  - ready_out = onehot(grant) & {NUM_REQ{can_load & |valid_in & !rst}}.
  - At most one ready_out bit is high per cycle.
  - ready_out never asserts for a requester whose valid_in is low.
- Transfer:
  - A requester transfer occurs when valid_in[i] & ready_out[i].
  - At the next edge the output stage captures that requester's five fields; pk_valid_out=1; grant_idx_out=i; ptr=(i+1) mod NUM_REQ.
  - Latency: requester accept to pk_valid_out is 1 cycle.
- Hold:
  - While pk_valid_out=1 and pk_ready_in=0, all pk_* outputs and grant_idx_out stay stable.
  - ready_out is all-zero; ptr is unchanged.
- Drain: if pk_ready_in=1 and no valid_in is set, pk_valid_out clears at the next edge; fields hold their last value.
- Pointer rules:
  - ptr changes only on a transfer.
  - With a single active requester, that requester wins every cycle (no bubbles).
  - Fairness: a continuously-valid requester waits at most NUM_REQ-1 grants.
- Requester contract (checked by SVA):
  - valid_in[i] must not depend combinationally on ready_out[i].
  - Once asserted, valid_in[i] and its fields stay stable until the transfer.
- Width rule: no width conversion; fields pass through unchanged.
- Packetizer limit: the packetizer width check (WIDTH_IN+2*ADDRESS_WIDTH+2*VC_ADDRESS_WIDTH+3 ≤ packetizer WIDTH_OUT) is the integrator's responsibility.
- Non-power-of-2 NUM_REQ: wrap is explicit; a pointer value ≥ NUM_REQ is unreachable.

Decomposition:
- Shared package (lynx_noc_pkg):
  - Typedef req_fields_t, a struct of {ret_dst, ret_vc, dst, vc, data}, parameterised via widths passed as module parameters.
  - Function rr_pick(req vector, ptr) returning the winning index plus a found flag.
- One natural sub-module: rr_arbiter_core.
  - Contains the pointer register, the combinational rotate-priority search, and the grant-update on an accept strobe.
  - Reusable for depacketizer-side sharing.
- The output stage and field mux stay in packetizer_arb_da.

Test Plan (NUM_REQ=4, WIDTH_IN=12):
- Reset: hold rst=1 for 2 cycles with valid_in=4'b1111 → ready_out=0 and pk_valid_out=0 throughout. After rst drops, the first grant is to requester 0 and pk_data_out equals req0's data one cycle later.
- Full contention, pk_ready_in=1, all valid for 8 cycles with data_in[i]=12'h100+i → pk_data_out sequence is 100,101,102,103,100,101,102,103 with no bubbles.
- Backpressure: pk_ready_in=0 for 5 cycles with word 12'hABC from req2 held → outputs stable and ready_out=0 throughout. When pk_ready_in goes to 1, the next word loads in that same cycle.
- Sparse: only req3 valid for 4 cycles → req3 is granted every cycle. When req1 becomes valid, ptr=0 at that point and req1 wins before req3.
- Wrap-around: ptr=3 with valid_in=4'b1001 → req3 is granted, then req0; ptr reads 0 then 1.
- Reset mid-operation: assert rst while pk_valid_out=1 and pk_ready_in=0 → pk_valid_out=0 and ptr=0 next cycle; no word is emitted.
